// File: rtl/mul_scheduler.sv
// Round-robin front end for one shared pipelined 32-bit multiplier: one grant per
// cycle, one outstanding multiply per thread, tagged results and per-thread flush.
module mul_scheduler #(
  parameter int NTHREADS = 4,
  parameter int LATENCY  = 4,
  parameter int TID_W    = $clog2(NTHREADS),
  parameter int REG_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NTHREADS-1:0]       req_valid,
  input  logic [NTHREADS*32-1:0]    req_a,
  input  logic [NTHREADS*32-1:0]    req_b,
  input  logic [NTHREADS*REG_W-1:0] req_dst,
  output logic [NTHREADS-1:0]       req_ready,
  input  logic                      flush_valid,
  input  logic [TID_W-1:0]          flush_thread,
  output logic                      out_valid,
  output logic [TID_W-1:0]          out_thread,
  output logic [REG_W-1:0]          out_dst,
  output logic [31:0]               out_data,
  output logic [NTHREADS-1:0]       busy
);

  logic [LATENCY-1:0]  valid_reg;
  logic [TID_W-1:0]    thread_reg [LATENCY];
  logic [REG_W-1:0]    dst_reg    [LATENCY];
  logic [31:0]         data_reg   [LATENCY];
  logic [NTHREADS-1:0] busy_reg;
  logic [NTHREADS-1:0] busy_next;
  logic [TID_W-1:0]    last_grant_reg;

  logic [LATENCY-1:0]  kill;
  logic [NTHREADS-1:0] retire;
  logic [NTHREADS-1:0] flushed;
  logic [NTHREADS-1:0] eligible;
  logic                grant_any;
  logic [TID_W-1:0]    grant_idx;
  logic [31:0]         a_sel;
  logic [31:0]         b_sel;
  logic [31:0]         prod;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_kill
      assign kill[gi] = flush_valid && (flush_thread == thread_reg[gi]);
    end
  endgenerate

  // A flushed result is hidden in the very cycle it reaches the last stage.
  assign out_valid  = valid_reg[LATENCY-1] && !kill[LATENCY-1];
  assign out_thread = thread_reg[LATENCY-1];
  assign out_dst    = dst_reg[LATENCY-1];
  assign out_data   = data_reg[LATENCY-1];
  assign busy       = busy_reg;

  generate
    for (gi = 0; gi < NTHREADS; gi++) begin : g_thread
      assign retire[gi]   = out_valid && (out_thread == TID_W'(gi));
      assign flushed[gi]  = flush_valid && (flush_thread == TID_W'(gi));
      assign eligible[gi] = req_valid[gi] && (!busy_reg[gi] || retire[gi]) && !flushed[gi];
      assign busy_next[gi] = req_ready[gi] ? 1'b1
                           : (retire[gi] || flushed[gi]) ? 1'b0
                           : busy_reg[gi];
    end
  endgenerate

  always_comb begin
    logic [TID_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = last_grant_reg;
    for (int i = 1; i <= NTHREADS; i++) begin
      idx = last_grant_reg + TID_W'(i);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Grants are masked while reset is held so nothing appears accepted.
  assign req_ready = (grant_any && rst) ? (NTHREADS'(1) << grant_idx) : '0;

  assign a_sel = req_a[grant_idx*32 +: 32];
  assign b_sel = req_b[grant_idx*32 +: 32];
  assign prod  = a_sel * b_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg      <= '0;
      busy_reg       <= '0;
      last_grant_reg <= TID_W'(NTHREADS - 1);
      for (int s = 0; s < LATENCY; s++) begin
        thread_reg[s] <= '0;
        dst_reg[s]    <= '0;
        data_reg[s]   <= '0;
      end
    end else begin
      valid_reg[0] <= grant_any;
      if (grant_any) begin
        thread_reg[0]  <= grant_idx;
        dst_reg[0]     <= req_dst[grant_idx*REG_W +: REG_W];
        data_reg[0]    <= prod;
        last_grant_reg <= grant_idx;
      end
      for (int s = 1; s < LATENCY; s++) begin
        valid_reg[s]  <= valid_reg[s-1] && !kill[s-1];
        thread_reg[s] <= thread_reg[s-1];
        dst_reg[s]    <= dst_reg[s-1];
        data_reg[s]   <= data_reg[s-1];
      end
      busy_reg <= busy_next;
    end
  end

endmodule

// File: doc/mul_scheduler.md
# mul_scheduler

Shares one pipelined 32-bit multiplier among the hardware threads of the datapath. It sits beside the EX stage, where multiply instructions are handed off and their results are returned to writeback. Each cycle it accepts at most one request, chosen by round-robin. It tracks one outstanding multiply per thread, returns results tagged with thread and destination register after a fixed latency, and discards in-flight work of a thread that is flushed.

## Interface
Parameters:
- NTHREADS, 4: number of requesting threads (≥2, power of two).
- LATENCY, 4: multiplier pipeline depth in cycles (≥1).
- TID_W, $clog2(NTHREADS): thread id width.
- REG_W, 5: destination register id width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NTHREADS  per-thread multiply request.
- req_a  in  NTHREADS*32  operand A; thread t in bits [32t+31:32t].
- req_b  in  NTHREADS*32  operand B, packed the same way.
- req_dst  in  NTHREADS*REG_W  destination register id per thread.
- req_ready  out  NTHREADS  one-hot grant; a request is accepted when req_valid[t]&req_ready[t].
- flush_valid  in  1  kill all work of flush_thread.
- flush_thread  in  TID_W  thread being flushed.
- out_valid  out  1  result available this cycle (no backpressure).
- out_thread  out  TID_W  thread of the result.
- out_dst  out  REG_W  destination register of the result.
- out_data  out  32  low 32 bits of a*b.
- busy  out  NTHREADS  thread has a multiply in flight.

## Operation
- Pipeline: LATENCY stage registers {valid, thread, dst, data}. The product is computed at stage 0 and carried unchanged through the remaining stages.
- Arithmetic: out_data = (req_a*req_b) mod 2^32; the operands are unsigned, which gives an identical low word for signed operands.
- Eligibility: thread t is eligible when all of the following hold:
  - req_valid[t] is set;
  - busy[t] is clear, or t's result is emerging this cycle (out_valid and out_thread==t);
  - t is not the target of an active flush (flush_valid && flush_thread==t).
- Arbitration: round-robin pointer last_grant. Search starts at last_grant+1 and wraps modulo NTHREADS. The first eligible thread gets req_ready. If no thread is eligible, req_ready=0 and last_grant is unchanged. On a grant, last_grant←granted thread.
- req_ready is combinational from the inputs and state; at most one bit is set.
- On acceptance: stage 0 is loaded with the request and busy[t] is set.
- busy[t] is cleared when t's result is presented with out_valid=1, or when t is flushed. If t is re-granted in the same cycle as its result, busy[t] stays set.
- Flush: every stage whose valid is set and whose thread matches flush_thread has its valid cleared at the edge. Results of the flushed thread are suppressed combinationally in the same cycle (out_valid=0). busy[flush_thread] is cleared. Other threads are unaffected.
- Output: out_valid is the last stage's valid, gated by the flush match. out_thread, out_dst and out_data come from the last stage and are don't-care when out_valid=0.

## Timing
- Request accepted at edge N → out_valid=1 during cycle N+LATENCY (the cycle after the edge N+LATENCY-1).
- Throughput: one accept per cycle across all threads; one outstanding multiply per thread.
- A thread can issue back-to-back results every LATENCY cycles, because re-grant is allowed in its result cycle.
- Reset (asynchronous, rst=0):
  - all stage valids=0, busy=0, out_valid=0, req_ready=0;
  - out_thread, out_dst and out_data=0;
  - last_grant=NTHREADS-1, so thread 0 has first priority.
- Reset asserted mid-operation drops all in-flight work; no result is emitted after release.
- A flush and a request from a different thread in the same cycle: the request is granted normally.
- A flush of a thread with nothing in flight is a no-op apart from keeping busy at 0.

## Test plan
- **Single multiply:** rst release; thread 1 requests a=7, b=6, dst=3 → req_ready=0010 that cycle; LATENCY=4 cycles later out_valid=1, out_thread=1, out_dst=3, out_data=42; busy[1] low afterwards.
- **Wrap and fairness:** all four threads request continuously → grants 0,1,2,3 on consecutive cycles, then each thread is re-granted in its own result cycle. Check the results:
  - a=0xFFFFFFFF, b=2 → out_data=0xFFFFFFFE;
  - a=0x10000, b=0x10000 → out_data=0.
- **Busy blocking:** thread 2 is granted, then holds req_valid → req_ready[2]=0 for 3 cycles; it is re-granted in the cycle its result has out_valid=1.
- **Flush:** threads 0 and 1 are granted in consecutive cycles; flush_thread=0 two cycles later → no result for thread 0; thread 1's result arrives on time; busy[0] clears at the flush edge.
- **Flush at emergence:** flush thread 3 in the exact cycle its result has the last-stage valid set → out_valid=0 that cycle, and a thread 3 request in the same cycle is not granted.
- **Reset mid-flight:** pull rst low with 3 ops in flight → all outputs are 0 immediately; after release no out_valid appears and thread 0 wins the first arbitration.
